turn_board_writer: RTL
======================

Name: turn_board_writer

Overview:
- Consumer end of the turn-commit interface: receives the 2-bit turn code from the turn-memory block, writes the current player's mark into a 3x3 board register, and passes the turn to the other player.
- Detects win, draw and per-turn timeout.
- Feeds the display/VGA logic with the board state and game status.

Parameters:
- TIMEOUT_CYCLES, 50000000, cycles without a commit before the turn passes automatically (1 s at 50 MHz).
- CNT_W, 26, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- turn_code  input  2  from turn memory: 01 = commit move, 00 = idle, 10/11 = ignored
- pos  input  4  cell index for the move, 0..8 row-major; sampled on the commit edge
- new_game  input  1  synchronous single-cycle clear of board and status, same effect as rst
- board  output  18  cell i at bits [2i+1:2i]: 00 empty, 01 player 0, 10 player 1
- player  output  1  player whose turn it is
- ack  output  1  one-cycle pulse: move accepted
- reject  output  1  one-cycle pulse: move refused (occupied cell or pos > 8)
- timeout  output  1  one-cycle pulse: turn passed by timeout
- win  output  1  level: a player completed a line
- winner  output  1  valid while win=1
- draw  output  1  level: board full, no win

Behaviour:
- Reset and new_game:
  - Reset (rst=1 at a clock edge) sets board=0, player=0, ack=reject=timeout=0, win=winner=draw=0, timeout counter=0, state WAIT.
  - new_game has identical effect and takes priority over a same-cycle commit.
  - Reset mid-operation aborts any in-flight write; the board is not updated.
- Commit detection:
  - Registered copy of turn_code.
  - A commit event occurs when turn_code==01 and the previous sample was !=01, so a held 01 commits once.
  - Codes 10/11 are never commits.
- FSM states: WAIT, WRITE, CHECK, OVER.
- WAIT:
  - Timeout counter increments each cycle.
  - On a commit event, latch pos and go to WRITE (counter cleared).
  - If the counter reaches TIMEOUT_CYCLES-1 with no commit: pulse timeout, toggle player, clear the counter, stay in WAIT.
  - Commit and timeout in the same cycle: the commit wins, no timeout pulse.
- WRITE, one cycle:
  - If latched pos > 8 or the cell is non-empty: pulse reject, return to WAIT, player unchanged.
  - Otherwise write {player==1, player==0} into the cell, pulse ack, go to CHECK.
  - Timing: commit seen at edge N -> board updated and ack high after edge N+1.
- CHECK, one cycle, evaluates the 8 lines (3 rows, 3 cols, 2 diagonals) against the mark just written:
  - Line complete: set win=1, winner=player, go to OVER; player does not toggle.
  - Else all 9 cells non-empty: set draw=1, go to OVER.
  - Else toggle player, return to WAIT. Player valid after edge N+2.
- Commits arriving in WRITE or CHECK are dropped; the producer must wait for ack/reject.
- OVER:
  - Commits ignored, timeout counter held at 0, board/win/draw/winner held.
  - Exits only via rst or new_game.
- ack, reject and timeout are mutually exclusive and never high longer than one cycle.

Test Plan:
- Reset, then commit pos=4 -> after 2 edges board[9:8]=01, ack 1 cycle, then player=1; all other cells 00.
- Hold turn_code=01 for 10 cycles with pos=0 -> exactly one ack, board[1:0]=01.
- Commit pos=4 as player 1 onto an occupied cell -> reject 1 cycle, board unchanged, player stays 1. Commit pos=9 -> reject.
- TIMEOUT_CYCLES=8, no commits -> timeout pulse every 8 cycles, player toggles 0->1->0. Commit on the 8th cycle -> ack, no timeout pulse.
- Moves P0:0, P1:3, P0:1, P1:4, P0:2 -> win=1, winner=0, player=0. A further commit is ignored (no ack/reject). new_game -> board=0, win=0.
- Nine moves 0,1,2,4,3,5,7,6,8 alternating -> draw=1, win=0, board fully non-empty. Assert rst mid-WRITE -> board cleared, no ack.

Source files
------------

// File: rtl/turn_board_writer_if.sv
// Turn-commit handshake between the turn-memory producer and the board writer.
interface turn_board_writer_if;
    logic [1:0] turn_code;
    logic [3:0] pos;
    logic       ack;
    logic       reject;

    modport master (output turn_code, output pos, input ack, input reject);
    modport slave  (input turn_code, input pos, output ack, output reject);
endinterface

// File: rtl/turn_board_writer.sv
// Tic-tac-toe board writer: applies committed moves to a 3x3 board, alternates players,
// and reports win, draw and per-turn timeout to the display logic.
module turn_board_writer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    turn_board_writer_if.slave   commit_bus,
    input  logic                 new_game,
    output logic [17:0]          board,
    output logic                 player,
    output logic                 timeout,
    output logic                 win,
    output logic                 winner,
    output logic                 draw
);

    typedef enum logic [1:0] {StWait, StWrite, StCheck, StOver} state_e;

    state_e           state_q, state_d;
    logic [1:0]       turn_code_q;
    logic [3:0]       pos_q, pos_d;
    logic [17:0]      board_q, board_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             player_q, player_d;
    logic             ack_q, ack_d;
    logic             reject_q, reject_d;
    logic             timeout_q, timeout_d;
    logic             win_q, win_d;
    logic             winner_q, winner_d;
    logic             draw_q, draw_d;

    logic             commit_evt;
    logic             cnt_done;
    logic [1:0]       mark;
    logic [8:0]       occ;
    logic [15:0]      busy;
    logic             cell_bad;
    logic             line_hit;
    logic             full;

    function automatic logic line3(input logic [17:0] b, input logic [1:0] m,
                                   input int unsigned a, input int unsigned c,
                                   input int unsigned d);
        return (b[2*a +: 2] == m) && (b[2*c +: 2] == m) && (b[2*d +: 2] == m);
    endfunction

    // Rising edge onto 01 only, so a held commit code writes once.
    assign commit_evt = (commit_bus.turn_code == 2'b01) && (turn_code_q != 2'b01);
    assign cnt_done   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mark       = {player_q, ~player_q};

    always_comb begin
        occ = '0;
        for (int i = 0; i < 9; i++) begin
            occ[i] = |board_q[2*i +: 2];
        end
    end

    // Indices 9..15 read as busy so out-of-range positions reject like occupied cells.
    assign busy     = {7'h7f, occ};
    assign cell_bad = busy[pos_q];
    assign full     = &occ;

    assign line_hit = line3(board_q, mark, 0, 1, 2) || line3(board_q, mark, 3, 4, 5) ||
                      line3(board_q, mark, 6, 7, 8) || line3(board_q, mark, 0, 3, 6) ||
                      line3(board_q, mark, 1, 4, 7) || line3(board_q, mark, 2, 5, 8) ||
                      line3(board_q, mark, 0, 4, 8) || line3(board_q, mark, 2, 4, 6);

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state_q     <= StWait;
            turn_code_q <= 2'b00;
            pos_q       <= '0;
            board_q     <= '0;
            cnt_q       <= '0;
            player_q    <= 1'b0;
            ack_q       <= 1'b0;
            reject_q    <= 1'b0;
            timeout_q   <= 1'b0;
            win_q       <= 1'b0;
            winner_q    <= 1'b0;
            draw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            turn_code_q <= commit_bus.turn_code;
            pos_q       <= pos_d;
            board_q     <= board_d;
            cnt_q       <= cnt_d;
            player_q    <= player_d;
            ack_q       <= ack_d;
            reject_q    <= reject_d;
            timeout_q   <= timeout_d;
            win_q       <= win_d;
            winner_q    <= winner_d;
            draw_q      <= draw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait:  if (commit_evt) state_d = StWrite;
            StWrite: state_d = cell_bad ? StWait : StCheck;
            StCheck: state_d = (line_hit || full) ? StOver : StWait;
            StOver:  state_d = StOver;
            default: state_d = StWait;
        endcase
    end

    always_comb begin
        pos_d     = pos_q;
        board_d   = board_q;
        cnt_d     = '0;
        player_d  = player_q;
        ack_d     = 1'b0;
        reject_d  = 1'b0;
        timeout_d = 1'b0;
        win_d     = win_q;
        winner_d  = winner_q;
        draw_d    = draw_q;
        unique case (state_q)
            StWait: begin
                if (commit_evt) begin
                    pos_d = commit_bus.pos;
                end else if (cnt_done) begin
                    timeout_d = 1'b1;
                    player_d  = ~player_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWrite: begin
                if (cell_bad) begin
                    reject_d = 1'b1;
                end else begin
                    for (int i = 0; i < 9; i++) begin
                        if (pos_q == 4'(i)) board_d[2*i +: 2] = mark;
                    end
                    ack_d = 1'b1;
                end
            end
            StCheck: begin
                if (line_hit) begin
                    win_d    = 1'b1;
                    winner_d = player_q;
                end else if (full) begin
                    draw_d = 1'b1;
                end else begin
                    player_d = ~player_q;
                end
            end
            StOver: begin
            end
            default: begin
            end
        endcase
    end

    assign commit_bus.ack    = ack_q;
    assign commit_bus.reject = reject_q;
    assign board             = board_q;
    assign player            = player_q;
    assign timeout           = timeout_q;
    assign win               = win_q;
    assign winner            = winner_q;
    assign draw              = draw_q;

endmodule
